wb_cmd_initiator: RTL and testbench
===================================

// Module: wb_cmd_initiator
// PURPOSE
//  Wishbone classic single-transfer initiator (bus master) for the user area. Accepts one
//  read/write command on a valid/ready port and runs it as one CYC/STB cycle toward a
//  Wishbone responder, such as the timer block. Returns read data and a status on a
//  valid/ready response port. Lets on-chip logic (IO-pad bridge, LA sequencer) drive
//  user-area slaves as the management core does.
// PARAMETERS
//  AW              32   address width
//  DW              32   data width (SEL width = DW/8)
//  TIMEOUT_CYCLES  255  max STB-high cycles before abort; legal range 2..65535
// PORTS
//  wb_clk_i     in   1      clock
//  wb_rst_i     in   1      async reset, active-high
//  cmd_valid    in   1      command offered
//  cmd_ready    out  1      command accepted when valid&ready at rising edge
//  cmd_we       in   1      1=write, 0=read
//  cmd_adr      in   AW     byte address
//  cmd_dat      in   DW     write data
//  cmd_sel      in   DW/8   byte selects
//  rsp_valid    out  1      response available
//  rsp_ready    in   1      response consumed when valid&ready at rising edge
//  rsp_dat      out  DW     read data (0 for writes and for errors)
//  rsp_code     out  2      00 OK, 01 BUS_ERR, 10 TIMEOUT, 11 reserved
//  wbm_cyc_o    out  1      bus cycle
//  wbm_stb_o    out  1      strobe
//  wbm_we_o     out  1      write enable
//  wbm_sel_o    out  DW/8   byte selects
//  wbm_adr_o    out  AW     address
//  wbm_dat_o    out  DW     write data
//  wbm_dat_i    in   DW     read data
//  wbm_ack_i    in   1      responder ack
//  wbm_err_i    in   1      responder error
//  irq_o        out  1      one-cycle pulse on every non-OK response
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE. All wbm_* outputs 0. rsp_valid=0,
//   rsp_dat=0, rsp_code=00, irq_o=0, timer=0. cmd_ready=0 while wb_rst_i is high.
//  All outputs are registered except cmd_ready = (state==IDLE) & ~wb_rst_i.
//  FSM states: IDLE -> BUS -> RESP -> IDLE.
//  IDLE: on cmd_valid&cmd_ready, latch we/adr/dat/sel into wbm_* and set cyc=stb=1. The
//   timer clears and the state goes to BUS. wbm_dat_o is 0 for reads.
//  BUS: cyc, stb and all wbm_* outputs are held stable. Each edge samples ack/err.
//   - err=1 (wins over a simultaneous ack): drop cyc/stb, rsp_code=01, rsp_dat=0, go RESP.
//   - ack=1, err=0: drop cyc/stb, rsp_dat = we ? 0 : wbm_dat_i, rsp_code=00, go RESP.
//   - neither, timer==TIMEOUT_CYCLES-1: drop cyc/stb, rsp_code=10, rsp_dat=0, go RESP.
//   - otherwise increment the timer (width $clog2(TIMEOUT_CYCLES)).
//   A timed-out cycle therefore has STB high exactly TIMEOUT_CYCLES cycles.
//  RESP: rsp_valid=1. rsp_dat/rsp_code hold stable until rsp_valid&rsp_ready, then
//   rsp_valid=0 and the state goes to IDLE.
//  irq_o=1 for exactly the first RESP cycle when rsp_code!=00.
//  Latency: command accepted at edge 0 -> STB high from cycle 1. An ack sampled at edge k
//   gives rsp_valid from cycle k+1. The minimum is rsp_valid in cycle 2. Peak throughput
//   is one transfer per 3 cycles.
//  ack/err while cyc=0 (late ack after a timeout, spurious ack) are ignored.
//  A command offered in BUS/RESP waits (cmd_ready=0); the command interface must hold
//   its fields stable.
//  Reset during BUS: cyc/stb drop at once (async). The in-flight command and any pending
//   response are discarded; no rsp_valid after release.
// STRUCTURE
//  Package wb_init_pkg: state enum {IDLE,BUS,RESP}; rsp_code localparams RSP_OK,
//   RSP_BUS_ERR, RSP_TIMEOUT.
//  One sub-module, wb_timeout_ctr: clear/enable/expire counter parameterised by
//   TIMEOUT_CYCLES. Everything else is in the top FSM.
// TESTING
//  1 Write adr 0x3000_0004 dat 0xDEADBEEF sel 0xF, ack after 2 wait states -> we/stb high
//    3 cycles with fields stable, rsp_code 00, rsp_dat 0, irq_o 0.
//  2 Read, ack in the first STB cycle with wbm_dat_i 0x1234_5678 -> rsp_valid in cycle 2
//    after accept, rsp_dat 0x1234_5678, rsp_code 00.
//  3 TIMEOUT_CYCLES=8, no ack -> stb high exactly 8 cycles, rsp_code 10, irq_o 1-cycle
//    pulse. A late ack 2 cycles later changes nothing.
//  4 ack and err asserted together -> rsp_code 01, rsp_dat 0, irq_o pulse.
//  5 rsp_ready low 5 cycles with a second cmd_valid pending -> rsp_dat/rsp_code stable,
//    cmd_ready 0. The second command is accepted the cycle after the response handshake.
//  6 wb_rst_i pulsed mid-BUS -> cyc/stb 0 before the next edge. After release cmd_ready=1,
//    rsp_valid stays 0.

Source files
------------

// File: rtl/wb_init_pkg.sv
// Shared types and response codes for the Wishbone command initiator.
package wb_init_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_BUS_ERR = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;

endpackage

// File: rtl/wb_cmd_initiator_if.sv
// Command, response and Wishbone master signals of the initiator.
interface wb_cmd_initiator_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [AW-1:0]     cmd_adr;
  logic [DW-1:0]     cmd_dat;
  logic [DW/8-1:0]   cmd_sel;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_dat;
  logic [1:0]        rsp_code;

  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [DW/8-1:0]   wbm_sel_o;
  logic [AW-1:0]     wbm_adr_o;
  logic [DW-1:0]     wbm_dat_o;
  logic [DW-1:0]     wbm_dat_i;
  logic              wbm_ack_i;
  logic              wbm_err_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
           wbm_dat_i, wbm_ack_i, wbm_err_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_code,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
           wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_code,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_timeout_ctr.sv
// Counts STB-high cycles; expire marks the last permitted cycle of a transfer.
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255,
  localparam int TW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  logic [TW-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expire = (count_reg == TW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/wb_cmd_initiator.sv
// Single-transfer Wishbone classic initiator driven by a valid/ready command port.
module wb_cmd_initiator
  import wb_init_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_cmd_initiator_if.master   bus,
  output logic                 irq_o
);
  state_t            state_reg;
  logic              cyc_reg;
  logic              stb_reg;
  logic              we_reg;
  logic [DW/8-1:0]   sel_reg;
  logic [AW-1:0]     adr_reg;
  logic [DW-1:0]     dat_o_reg;
  logic              rsp_valid_reg;
  logic [DW-1:0]     rsp_dat_reg;
  logic [1:0]        rsp_code_reg;
  logic              irq_reg;

  logic              accept;
  logic              timer_en;
  logic              timer_expire;

  assign bus.cmd_ready = (state_reg == IDLE) & ~wb_rst_i;
  assign accept        = (state_reg == IDLE) & bus.cmd_valid;
  assign timer_en      = (state_reg == BUS) & ~bus.wbm_ack_i & ~bus.wbm_err_i & ~timer_expire;

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (accept),
    .enable (timer_en),
    .expire (timer_expire)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg     <= IDLE;
      cyc_reg       <= 1'b0;
      stb_reg       <= 1'b0;
      we_reg        <= 1'b0;
      sel_reg       <= '0;
      adr_reg       <= '0;
      dat_o_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_dat_reg   <= '0;
      rsp_code_reg  <= RSP_OK;
      irq_reg       <= 1'b0;
    end else begin
      irq_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            cyc_reg   <= 1'b1;
            stb_reg   <= 1'b1;
            we_reg    <= bus.cmd_we;
            sel_reg   <= bus.cmd_sel;
            adr_reg   <= bus.cmd_adr;
            dat_o_reg <= bus.cmd_we ? bus.cmd_dat : '0;
            state_reg <= BUS;
          end
        end
        BUS: begin
          // err takes priority over a simultaneous ack
          if (bus.wbm_err_i) begin
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            rsp_code_reg  <= RSP_BUS_ERR;
            rsp_dat_reg   <= '0;
            rsp_valid_reg <= 1'b1;
            irq_reg       <= 1'b1;
            state_reg     <= RESP;
          end else if (bus.wbm_ack_i) begin
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            rsp_code_reg  <= RSP_OK;
            rsp_dat_reg   <= we_reg ? '0 : bus.wbm_dat_i;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else if (timer_expire) begin
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            rsp_code_reg  <= RSP_TIMEOUT;
            rsp_dat_reg   <= '0;
            rsp_valid_reg <= 1'b1;
            irq_reg       <= 1'b1;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.wbm_cyc_o = cyc_reg;
  assign bus.wbm_stb_o = stb_reg;
  assign bus.wbm_we_o  = we_reg;
  assign bus.wbm_sel_o = sel_reg;
  assign bus.wbm_adr_o = adr_reg;
  assign bus.wbm_dat_o = dat_o_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_dat   = rsp_dat_reg;
  assign bus.rsp_code  = rsp_code_reg;
  assign irq_o         = irq_reg;
endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed table-driven bench for wb_cmd_initiator with TIMEOUT_CYCLES=8.
module tb_wb_cmd_initiator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_cmd_initiator_if #(.AW(32), .DW(32)) bus ();

  wb_cmd_initiator #(
    .AW(32), .DW(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .irq_o    (irq)
  );

  // kind: bit0 = ack, bit1 = err, 0 = responder stays silent
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          waits;
    logic [1:0]  kind;
    logic [31:0] dat_i;
    int          exp_stb;
    logic [1:0]  exp_code;
    logic [31:0] exp_dat;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    cyc_n;
    int    wait_n;
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = v.we;
    bus.cmd_adr   = v.adr;
    bus.cmd_dat   = v.dat;
    bus.cmd_sel   = v.sel;
    wait_n = 0;
    while (!bus.cmd_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    chk({t, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    cyc_n = 0;
    while (bus.wbm_stb_o && cyc_n < 40) begin
      cyc_n++;
      chk({t, ".adr"}, bus.wbm_adr_o, v.adr);
      chk({t, ".we"},  32'(bus.wbm_we_o), 32'(v.we));
      chk({t, ".sel"}, 32'(bus.wbm_sel_o), 32'(v.sel));
      chk({t, ".dat_o"}, bus.wbm_dat_o, v.we ? v.dat : 32'd0);
      chk({t, ".cyc"}, 32'(bus.wbm_cyc_o), 32'd1);
      if (v.kind != 2'd0 && cyc_n == v.waits + 1) begin
        bus.wbm_ack_i = v.kind[0];
        bus.wbm_err_i = v.kind[1];
        bus.wbm_dat_i = v.dat_i;
      end
      @(negedge clk);
      bus.wbm_ack_i = 1'b0;
      bus.wbm_err_i = 1'b0;
      bus.wbm_dat_i = 32'd0;
    end
    chk({t, ".stb_cycles"}, 32'(cyc_n), 32'(v.exp_stb));
    chk({t, ".cyc_drop"}, 32'(bus.wbm_cyc_o), 32'd0);
    chk({t, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({t, ".rsp_code"}, 32'(bus.rsp_code), 32'(v.exp_code));
    chk({t, ".rsp_dat"}, bus.rsp_dat, v.exp_dat);
    chk({t, ".irq"}, 32'(irq), 32'(v.exp_irq));
    @(negedge clk);
    chk({t, ".irq_end"}, 32'(irq), 32'd0);
    if (v.kind == 2'd0) begin
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'hFFFF_FFFF;
    end
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'd0;
    chk({t, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({t, ".hold_code"}, 32'(bus.rsp_code), 32'(v.exp_code));
    chk({t, ".hold_dat"}, bus.rsp_dat, v.exp_dat);
    chk({t, ".hold_cyc"}, 32'(bus.wbm_cyc_o), 32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({t, ".rsp_done"}, 32'(bus.rsp_valid), 32'd0);
    chk({t, ".ready_again"}, 32'(bus.cmd_ready), 32'd1);
    $display("vector %0d: we=%0b adr=0x%08h stb_cycles=%0d code=%0d dat=0x%08h",
             idx, v.we, v.adr, cyc_n, bus.rsp_code, bus.rsp_dat);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = 32'd0;
    bus.cmd_dat   = 32'd0;
    bus.cmd_sel   = 4'd0;
    bus.rsp_ready = 1'b0;
    bus.wbm_dat_i = 32'd0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_err_i = 1'b0;

    //         we    adr            dat            sel   w  kind  dat_i          stb code  exp_dat        irq
    tbl[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 2'd1, 32'h55AA_55AA, 3, 2'd0, 32'h0,         1'b0};
    tbl[1] = '{1'b0, 32'h3000_0008, 32'h0,         4'hF, 0, 2'd1, 32'h1234_5678, 1, 2'd0, 32'h1234_5678, 1'b0};
    tbl[2] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 0, 2'd0, 32'h0,         8, 2'd2, 32'h0,         1'b1};
    tbl[3] = '{1'b1, 32'h3000_000C, 32'h0BAD_F00D, 4'h3, 1, 2'd3, 32'hCAFE_BABE, 2, 2'd1, 32'h0,         1'b1};
    tbl[4] = '{1'b0, 32'h3000_0014, 32'h0,         4'hF, 3, 2'd2, 32'h7777_7777, 4, 2'd1, 32'h0,         1'b1};
    tbl[5] = '{1'b0, 32'h3000_0018, 32'h0,         4'h4, 4, 2'd1, 32'h00C0_FFEE, 5, 2'd0, 32'h00C0_FFEE, 1'b0};
    tbl[6] = '{1'b1, 32'h3000_001C, 32'hA5A5_5A5A, 4'hC, 0, 2'd0, 32'h0,         8, 2'd2, 32'h0,         1'b1};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst.cyc", 32'(bus.wbm_cyc_o), 32'd0);
    chk("rst.stb", 32'(bus.wbm_stb_o), 32'd0);
    chk("rst.we", 32'(bus.wbm_we_o), 32'd0);
    chk("rst.adr", bus.wbm_adr_o, 32'd0);
    chk("rst.dat_o", bus.wbm_dat_o, 32'd0);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.rsp_dat", bus.rsp_dat, 32'd0);
    chk("rst.rsp_code", 32'(bus.rsp_code), 32'd0);
    chk("rst.irq", 32'(irq), 32'd0);
    chk("rst.cmd_ready", 32'(bus.cmd_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    $display("reset: checked outputs, cmd_ready=%0b after release", bus.cmd_ready);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // back-pressured response with a second command waiting
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = 32'h3000_0020;
    bus.cmd_sel   = 4'hF;
    @(negedge clk);
    chk("bp.stb", 32'(bus.wbm_stb_o), 32'd1);
    bus.cmd_valid = 1'b0;
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'hA5A5_0F0F;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'd0;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_adr   = 32'h3000_0024;
    bus.cmd_dat   = 32'h1122_3344;
    for (int i = 0; i < 5; i++) begin
      chk("bp.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp.rsp_code", 32'(bus.rsp_code), 32'd0);
      chk("bp.rsp_dat", bus.rsp_dat, 32'hA5A5_0F0F);
      chk("bp.cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("bp.stb_low", 32'(bus.wbm_stb_o), 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp.rsp_cleared", 32'(bus.rsp_valid), 32'd0);
    chk("bp.cmd_ready_next", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("bp.second_stb", 32'(bus.wbm_stb_o), 32'd1);
    chk("bp.second_adr", bus.wbm_adr_o, 32'h3000_0024);
    chk("bp.second_dat", bus.wbm_dat_o, 32'h1122_3344);
    bus.wbm_ack_i = 1'b1;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    chk("bp.second_rsp", 32'(bus.rsp_valid), 32'd1);
    chk("bp.second_dat0", bus.rsp_dat, 32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    $display("backpressure: held 5 cycles, second command accepted after handshake");

    // reset asserted in the middle of a bus cycle
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = 32'h3000_0030;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("rb.stb", 32'(bus.wbm_stb_o), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rb.cyc_async", 32'(bus.wbm_cyc_o), 32'd0);
    chk("rb.stb_async", 32'(bus.wbm_stb_o), 32'd0);
    chk("rb.cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rb.ready_after", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rb.no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("rb.idle_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    end
    $display("reset mid-bus: cyc=%0b rsp_valid=%0b cmd_ready=%0b",
             bus.wbm_cyc_o, bus.rsp_valid, bus.cmd_ready);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
